// File: rtl/vc_test_multi_delay_source_pkg.sv
// Shared types and constants for the multi-channel delayed test source.
// Holds the gap modes, the channel FSM states and the LFSR helpers.
package vc_test_multi_delay_source_pkg;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_RAND  = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] SEED_MIX  = 16'h9E37;

    // A zero seed would lock the LFSR, so it is forced to 1.
    function automatic logic [15:0] chan_seed(input logic [15:0] base, input int c);
        logic [15:0] s;
        s = base ^ 16'(c * SEED_MIX);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    function automatic logic [7:0] rand_gap(input logic [7:0] hi, input logic [7:0] md);
        logic [15:0] p;
        p = {8'd0, hi} * ({8'd0, md} + 16'd1);
        return p[15:8];
    endfunction

endpackage

// File: rtl/vc_test_delay_chan.sv
// One channel of the test source: message memory, load count, issue index,
// gap FSM, per-channel LFSR and burst counter.
module vc_test_delay_chan
    import vc_test_multi_delay_source_pkg::*;
#(
    parameter int          p_msg_nbits = 32,
    parameter int          p_num_msgs  = 1024,
    parameter logic [15:0] p_seed_chan = 16'h0001
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load_en,
    input  logic [p_msg_nbits-1:0] i_load_msg,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic [7:0]             i_max_delay,
    input  logic [7:0]             i_burst_len,
    input  logic                   i_rdy,
    output logic                   o_val,
    output logic [p_msg_nbits-1:0] o_msg,
    output logic                   o_done
);

    localparam int IW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
    localparam int NW = $clog2(p_num_msgs + 1);

    logic [p_msg_nbits-1:0] r_mem [p_num_msgs];

    state_t      r_state, w_state_nxt;
    mode_t       r_mode, w_mode;
    logic [NW-1:0] r_cnt, w_cnt_eff;
    logic [IW-1:0] r_idx;
    logic [7:0]  r_gcnt, r_bcnt, r_maxd, r_blen;
    logic [15:0] r_lfsr;
    logic [7:0]  w_maxd, w_blen, w_gap;
    logic        w_load_ok, w_hs, w_last, w_draw, w_burst_end;

    assign w_load_ok = i_load_en && (r_state == ST_IDLE) && (r_cnt != NW'(p_num_msgs));
    assign w_cnt_eff = r_cnt + NW'(w_load_ok);
    assign w_hs      = (r_state == ST_SEND) && i_rdy;
    assign w_last    = (NW'(r_idx) + NW'(1)) == r_cnt;

    // In IDLE the first gap is drawn from the live config; afterwards from the copy taken at start.
    always_comb begin
        w_mode = r_mode;
        w_maxd = r_maxd;
        w_blen = r_blen;
        if (r_state == ST_IDLE) begin
            w_mode = mode_t'(i_mode);
            w_maxd = i_max_delay;
            w_blen = i_burst_len;
        end
        if (w_blen == 8'd0) w_blen = 8'd1;
        w_burst_end = ({1'b0, r_bcnt} + 9'd1) == {1'b0, w_blen};
        w_gap = 8'd0;
        case (w_mode)
            MODE_FIXED: w_gap = w_maxd;
            MODE_RAND:  w_gap = rand_gap(r_lfsr[15:8], w_maxd);
            MODE_BURST: w_gap = ((r_state != ST_IDLE) && w_burst_end) ? w_maxd : 8'd0;
            default:    w_gap = 8'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_draw      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (w_cnt_eff == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_draw      = 1'b1;
                        w_state_nxt = (w_gap == 8'd0) ? ST_SEND : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gcnt <= 8'd1) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_draw      = 1'b1;
                        w_state_nxt = (w_gap == 8'd0) ? ST_SEND : ST_GAP;
                    end
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_gcnt <= 8'd0;
            r_bcnt <= 8'd0;
            r_maxd <= 8'd0;
            r_blen <= 8'd0;
            r_mode <= MODE_NONE;
            r_lfsr <= p_seed_chan;
        end else begin
            if (w_load_ok) r_cnt <= r_cnt + NW'(1);
            if ((r_state == ST_IDLE) && i_start) begin
                r_mode <= mode_t'(i_mode);
                r_maxd <= i_max_delay;
                r_blen <= i_burst_len;
                r_bcnt <= 8'd0;
            end
            if (r_state == ST_GAP) r_gcnt <= r_gcnt - 8'd1;
            if (w_draw) begin
                r_gcnt <= w_gap;
                if (w_mode == MODE_RAND) r_lfsr <= lfsr_step(r_lfsr);
            end
            if (w_hs) begin
                r_idx  <= r_idx + IW'(1);
                r_bcnt <= w_burst_end ? 8'd0 : r_bcnt + 8'd1;
            end
        end
    end

    // Memory contents survive reset; only the count says what is valid.
    always_ff @(posedge i_clk) begin
        if (w_load_ok) r_mem[r_cnt[IW-1:0]] <= i_load_msg;
    end

    assign o_val  = (r_state == ST_SEND);
    assign o_msg  = r_mem[r_idx];
    assign o_done = (r_state == ST_DONE);

endmodule

// File: rtl/vc_test_multi_delay_source.sv
// Multi-channel val/rdy test source: decodes loads to channels, replicates
// the channel engine with distinct LFSR seeds and reduces done.
module vc_test_multi_delay_source
    import vc_test_multi_delay_source_pkg::*;
#(
    parameter int          p_msg_nbits = 32,
    parameter int          p_num_msgs  = 1024,
    parameter int          p_num_chans = 2,
    parameter logic [15:0] p_seed      = 16'hACE1
) (
    input  logic                                         i_clk,
    input  logic                                         i_reset,
    input  logic                                         i_load_en,
    input  logic [((p_num_chans > 1) ? $clog2(p_num_chans) : 1)-1:0] i_load_chan,
    input  logic [p_msg_nbits-1:0]                       i_load_msg,
    input  logic                                         i_start,
    input  logic [1:0]                                   i_mode,
    input  logic [7:0]                                   i_max_delay,
    input  logic [7:0]                                   i_burst_len,
    output logic [p_num_chans-1:0]                       o_val,
    input  logic [p_num_chans-1:0]                       i_rdy,
    output logic [p_num_chans*p_msg_nbits-1:0]           o_msg,
    output logic [p_num_chans-1:0]                       o_done,
    output logic                                         o_all_done
);

    localparam int CW = (p_num_chans > 1) ? $clog2(p_num_chans) : 1;

    for (genvar c = 0; c < p_num_chans; c++) begin : g_chan
        localparam logic [15:0] SEED = chan_seed(p_seed, c);
        logic w_load_sel;

        assign w_load_sel = i_load_en && (i_load_chan == CW'(c));

        vc_test_delay_chan #(
            .p_msg_nbits (p_msg_nbits),
            .p_num_msgs  (p_num_msgs),
            .p_seed_chan (SEED)
        ) u_chan (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_load_en   (w_load_sel),
            .i_load_msg  (i_load_msg),
            .i_start     (i_start),
            .i_mode      (i_mode),
            .i_max_delay (i_max_delay),
            .i_burst_len (i_burst_len),
            .i_rdy       (i_rdy[c]),
            .o_val       (o_val[c]),
            .o_msg       (o_msg[c*p_msg_nbits +: p_msg_nbits]),
            .o_done      (o_done[c])
        );
    end

    assign o_all_done = &o_done;

endmodule
